flexbex_clock_gate_ctrl: RTL and testbench

// - Multi-channel clock-gating controller for core sub-units (e.g. MUL/DIV, FPU, debug).
// - Per channel: idle-hysteresis FSM decides gating; latch-based ICG produces clk_o[ch].
// - Wake handshake guarantees a gated unit sees WAKE_CYCLES stable clocks before ack.
// - Sits between core clock root and sub-units; test_en_i forces all clocks on for DFT/scan.

---
 rtl/flexbex_clock_gate_ctrl.sv | 152 +++++++++++++++
 tb/tb_flexbex_clock_gate_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexbex_clock_gate_ctrl.sv
// Multi-channel clock-gating controller: idle-hysteresis FSM plus latch ICG per channel.
// Define FLEXBEX_CG_STATS_EN to build per-channel gated-cycle counters on gated_cnt_o.
module flexbex_clock_gate_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      test_en_i,
    input  logic [NUM_CH-1:0]         force_on_i,
    input  logic [NUM_CH-1:0]         idle_i,
    input  logic [NUM_CH-1:0]         wake_req_i,
    output logic [NUM_CH-1:0]         wake_ack_o,
    output logic [NUM_CH-1:0]         clk_o,
    output logic [NUM_CH-1:0]         gated_o,
    output logic [NUM_CH*CNT_W-1:0]   gated_cnt_o
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [3:0]    WAKE_LAST = 4'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_t;

    state_t        state_q [NUM_CH];
    state_t        state_d [NUM_CH];
    logic [IW-1:0] idle_q  [NUM_CH];
    logic [IW-1:0] idle_d  [NUM_CH];
    logic [3:0]    wake_q  [NUM_CH];
    logic [3:0]    wake_d  [NUM_CH];

    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] en_lat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= RUN;
                idle_q[ch]  <= '0;
                wake_q[ch]  <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                idle_q[ch]  <= idle_d[ch];
                wake_q[ch]  <= wake_d[ch];
            end
        end
    end

    // A wake request, a force or fresh work all count as "keep running".
    assign busy = wake_req_i | force_on_i | ~idle_i;

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            idle_d[ch]  = idle_q[ch];
            wake_d[ch]  = wake_q[ch];
            unique case (state_q[ch])
                RUN: begin
                    wake_d[ch] = '0;
                    if (busy[ch]) begin
                        idle_d[ch] = '0;
                    end else if (idle_q[ch] == IDLE_LAST) begin
                        state_d[ch] = GATED;
                        idle_d[ch]  = '0;
                    end else if (idle_q[ch] != {IW{1'b1}}) begin
                        idle_d[ch] = idle_q[ch] + 1'b1;
                    end
                end
                GATED: begin
                    idle_d[ch] = '0;
                    if (busy[ch]) begin
                        state_d[ch] = WAKE;
                        wake_d[ch]  = '0;
                    end
                end
                WAKE: begin
                    idle_d[ch] = '0;
                    if (wake_q[ch] == WAKE_LAST) begin
                        state_d[ch] = RUN;
                        wake_d[ch]  = '0;
                    end else begin
                        wake_d[ch] = wake_q[ch] + 4'd1;
                    end
                end
                default: begin
                    state_d[ch] = RUN;
                    idle_d[ch]  = '0;
                    wake_d[ch]  = '0;
                end
            endcase
        end
    end

    always_comb begin
        en         = '0;
        wake_ack_o = '0;
        gated_o    = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            en[ch]         = (state_q[ch] != GATED);
            wake_ack_o[ch] = (state_q[ch] == RUN);
            gated_o[ch]    = (state_q[ch] == GATED);
        end
    end

    // Enable is sampled only while clk_i is low, so clk_o cannot glitch.
    always_latch begin
        if (rst_i) begin
            en_lat <= '1;
        end else if (!clk_i) begin
            en_lat <= en;
        end
    end

    assign clk_o = {NUM_CH{clk_i}} & (en_lat | {NUM_CH{test_en_i}});

`ifdef FLEXBEX_CG_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (state_q[ch] == GATED) begin
                    cnt_q[ch] <= cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        gated_cnt_o = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            gated_cnt_o[ch*CNT_W +: CNT_W] = cnt_q[ch];
        end
    end
`else
    assign gated_cnt_o = '0;
`endif

endmodule

// File: tb/tb_flexbex_clock_gate_ctrl.sv
// Randomized self-checking bench for flexbex_clock_gate_ctrl.
// Reference model tracks idle runs and wake countdowns per channel.
module tb_flexbex_clock_gate_ctrl;

    localparam int NCH  = 4;
    localparam int IDLE = 8;
    localparam int WAKE = 2;
    localparam int CW   = 32;

    logic           clk_i      = 1'b0;
    logic           rst_i      = 1'b1;
    logic           test_en_i  = 1'b0;
    logic [NCH-1:0] force_on_i = '0;
    logic [NCH-1:0] idle_i     = '0;
    logic [NCH-1:0] wake_req_i = '0;
    logic [NCH-1:0] wake_ack_o;
    logic [NCH-1:0] clk_o;
    logic [NCH-1:0] gated_o;
    logic [NCH*CW-1:0] gated_cnt_o;

    int checks   = 0;
    int failures = 0;

    int run_cnt   [NCH];
    int wake_left [NCH];
    bit m_gated   [NCH];

    logic [NCH-1:0] clk_hi;
    logic [NCH-1:0] exp_clk_hi;
    int pulses0 = 0;

    flexbex_clock_gate_ctrl #(
        .NUM_CH(NCH), .IDLE_CYCLES(IDLE),
        .WAKE_CYCLES(WAKE), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .test_en_i(test_en_i),
        .force_on_i(force_on_i), .idle_i(idle_i),
        .wake_req_i(wake_req_i), .wake_ack_o(wake_ack_o),
        .clk_o(clk_o), .gated_o(gated_o), .gated_cnt_o(gated_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_o[0]) pulses0++;

    function automatic logic [NCH-1:0] exp_gated();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m_gated[i];
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_ack();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = !m_gated[i] && wake_left[i] == 0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            run_cnt[i] = 0; wake_left[i] = 0; m_gated[i] = 0;
        end
    endtask

    task automatic model_step();
        bit busy;
        for (int i = 0; i < NCH; i++) begin
            busy = wake_req_i[i] | force_on_i[i] | !idle_i[i];
            if (m_gated[i]) begin
                if (busy) begin
                    m_gated[i] = 0;
                    wake_left[i] = WAKE;
                end
            end else if (wake_left[i] > 0) begin
                wake_left[i]--;
            end else if (busy) begin
                run_cnt[i] = 0;
            end else begin
                run_cnt[i]++;
                if (run_cnt[i] == IDLE) begin
                    m_gated[i] = 1;
                    run_cnt[i] = 0;
                end
            end
        end
    endtask

    // One clock: sample clk_o in the high phase, advance model, return at negedge.
    task automatic cycle();
        @(posedge clk_i);
        #1;
        clk_hi = clk_o;
        for (int i = 0; i < NCH; i++) exp_clk_hi[i] = !m_gated[i] | test_en_i;
        if (rst_i) model_reset();
        else model_step();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if (wake_ack_o !== 4'b1111 || gated_o !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state ack=%b gated=%b exp ack=1111 gated=0000", wake_ack_o, gated_o);
        end
        rst_i = 1'b0;
        model_reset();
        repeat (3) cycle();
        checks++;
        if (clk_hi !== 4'b1111 || wake_ack_o !== 4'b1111 || gated_o !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release clk=%b ack=%b gated=%b exp 1111/1111/0000", clk_hi, wake_ack_o, gated_o);
        end
    endtask

    task automatic test_idle_gate();
        idle_i = 4'b0001;
        for (int k = 1; k <= IDLE; k++) begin
            cycle();
            checks++;
            if (gated_o[0] !== (k == IDLE)) begin
                failures++;
                $display("FAIL idle_gate k=%0d gated0=%b exp=%b", k, gated_o[0], k == IDLE);
            end
        end
        cycle();
        checks++;
        if (clk_hi !== 4'b1110 || gated_o !== 4'b0001) begin
            failures++;
            $display("FAIL gated_clk clk=%b gated=%b exp 1110/0001", clk_hi, gated_o);
        end
    endtask

    task automatic test_wake();
        int p0;
        p0 = pulses0;
        wake_req_i = 4'b0001;
        cycle();
        cycle();
        checks++;
        if (wake_ack_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL wake_early ack0=%b exp=0", wake_ack_o[0]);
        end
        cycle();
        checks++;
        if (wake_ack_o[0] !== 1'b1 || pulses0 - p0 != WAKE) begin
            failures++;
            $display("FAIL wake_ack ack0=%b pulses=%0d exp ack0=1 pulses=%0d", wake_ack_o[0], pulses0 - p0, WAKE);
        end
        wake_req_i = '0;
        idle_i = '0;
        cycle();
    endtask

    task automatic test_idle_drop();
        idle_i = 4'b0010;
        repeat (IDLE - 1) cycle();
        idle_i = 4'b0000;
        cycle();
        checks++;
        if (gated_o[1] !== 1'b0 || wake_ack_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL idle_drop gated1=%b ack1=%b exp 0/1", gated_o[1], wake_ack_o[1]);
        end
        idle_i = 4'b0010;
        repeat (IDLE - 1) cycle();
        checks++;
        if (gated_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL idle_restart gated1=%b exp=0", gated_o[1]);
        end
        cycle();
        checks++;
        if (gated_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL idle_regate gated1=%b exp=1", gated_o[1]);
        end
        idle_i = '0;
        repeat (WAKE + 2) cycle();
    endtask

    task automatic test_test_en();
        idle_i = 4'b0100;
        repeat (IDLE) cycle();
        test_en_i = 1'b1;
        repeat (2) cycle();
        checks++;
        if (clk_hi[2] !== 1'b1 || gated_o[2] !== 1'b1) begin
            failures++;
            $display("FAIL test_en clk2=%b gated2=%b exp 1/1", clk_hi[2], gated_o[2]);
        end
        test_en_i = 1'b0;
        cycle();
        checks++;
        if (clk_hi[2] !== 1'b0 || gated_o[2] !== 1'b1) begin
            failures++;
            $display("FAIL test_en_release clk2=%b gated2=%b exp 0/1", clk_hi[2], gated_o[2]);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (gated_o !== 4'b0000 || wake_ack_o !== 4'b1111 || clk_o[2] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid gated=%b ack=%b clk2=%b exp 0000/1111/1", gated_o, wake_ack_o, clk_o[2]);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_i = '0;
        model_reset();
        cycle();
    endtask

    task automatic test_stats();
        idle_i = 4'b1000;
        repeat (IDLE) cycle();
        repeat (100) cycle();
`ifdef FLEXBEX_CG_STATS_EN
        checks++;
        if (gated_cnt_o[3*CW +: CW] !== 32'd100 || gated_cnt_o[0 +: 3*CW] !== '0) begin
            failures++;
            $display("FAIL stats_cnt got=%0d exp=100", gated_cnt_o[3*CW +: CW]);
        end
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (gated_cnt_o !== '0 || clk_o[3] !== 1'b1) begin
            failures++;
            $display("FAIL stats_reset cnt=%0d clk3=%b exp 0/1", gated_cnt_o[3*CW +: CW], clk_o[3]);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
`else
        checks++;
        if (gated_cnt_o !== '0 || gated_o[3] !== 1'b1) begin
            failures++;
            $display("FAIL stats_off cnt=%h gated3=%b exp 0/1", gated_cnt_o, gated_o[3]);
        end
`endif
        idle_i = '0;
        repeat (WAKE + 2) cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            checks++;
            if (gated_o !== exp_gated() || wake_ack_o !== exp_ack()) begin
                failures++;
                $display("FAIL rand_status n=%0d gated=%b ack=%b exp gated=%b ack=%b",
                         n, gated_o, wake_ack_o, exp_gated(), exp_ack());
            end
            if (n > 0) begin
                checks++;
                if (clk_hi !== exp_clk_hi) begin
                    failures++;
                    $display("FAIL rand_clk n=%0d clk=%b exp=%b", n, clk_hi, exp_clk_hi);
                end
            end
            rst_i = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                idle_i[i]     = ($urandom_range(7) != 0);
                wake_req_i[i] = ($urandom_range(15) == 0);
                force_on_i[i] = ($urandom_range(31) == 0);
            end
            test_en_i = ($urandom_range(19) == 0);
            if ($urandom_range(499) == 0) begin
                rst_i = 1'b1;
                model_reset();
            end
            cycle();
        end
        rst_i = 1'b0;
        idle_i = '0;
        wake_req_i = '0;
        force_on_i = '0;
        test_en_i = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_gate();
        test_wake();
        test_idle_drop();
        test_test_en();
        test_reset_mid();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
